// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple-carry stage, one nibble per clock, LSB nibble first.
// Carry between nibbles lives in carry_q; partial sums are collected into sum_q.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             co_q, co_d;

   logic [3:0]       a_nib [NIBBLES];
   logic [3:0]       b_nib [NIBBLES];
   logic [3:0]       nib_a, nib_b, nib_s;
   logic [4:0]       rc;
   logic [WIDTH-1:0] sum_run;

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign a_nib[gi] = a_q[4*gi +: 4];
         assign b_nib[gi] = b_q[4*gi +: 4];
         // Only the nibble currently being processed takes the adder output.
         assign sum_run[4*gi +: 4] = (idx_q == IDX_W'(gi)) ? nib_s : sum_q[4*gi +: 4];
      end
   endgenerate

   assign nib_a = a_nib[idx_q];
   assign nib_b = b_nib[idx_q];
   assign rc[0] = carry_q;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_fa
         assign nib_s[gi]  = nib_a[gi] ^ nib_b[gi] ^ rc[gi];
         assign rc[gi + 1] = (nib_a[gi] & nib_b[gi]) | (rc[gi] & (nib_a[gi] ^ nib_b[gi]));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      co_d    = co_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = ci;
               sum_d   = '0;
               co_d    = 1'b0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d   = sum_run;
            carry_d = rc[4];
            if (idx_q == LAST_IDX) begin
               co_d    = rc[4];
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign co   = co_q;

endmodule
